// File: rtl/menwb_tb.sv
// MEM/WB back-end slice: EX/MEM register, byte data memory, MEM/WB register, writeback mux.
// Optional macro DEBUG_PORTS_EN exposes the MEM/WB rd and regwrite fields.
package menwb_pkg;

  typedef struct packed {
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [1:0]  aj;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] pcimm;
  } ex_mem_t;

  typedef struct packed {
    logic        memtoreg;
    logic        regwrite;
    logic [1:0]  aj;
    logic [31:0] alu;
    logic [31:0] ldata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] pcimm;
  } mem_wb_t;

endpackage

module menwb_tb #(
  parameter int DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memtoreg_IDEX_out,
  input  logic        regwrite_IDEX_out,
  input  logic        memread_IDEX_out,
  input  logic        memwrite_IDEX_out,
  input  logic [1:0]  AJ_control_IDEX_out,
  input  logic [31:0] ALU_result,
  input  logic [31:0] RD2_output,
  input  logic [3:0]  function3_out_IDEX_out,
  input  logic [4:0]  WData_IDEX_out,
  input  logic [31:0] adder1_IDEX,
  input  logic [31:0] adder2_EXMEM,
`ifdef DEBUG_PORTS_EN
  output logic [4:0]  wb_rd_o,
  output logic        wb_regwrite_o,
`endif
  output logic [31:0] regwrite_MEM_outt
);

  import menwb_pkg::*;

  localparam int AW = $clog2(DMEM_BYTES);

  ex_mem_t     w_ex_d;
  ex_mem_t     r_ex;
  mem_wb_t     w_wb_d;
  mem_wb_t     r_wb;

  logic [7:0]  r_mem [DMEM_BYTES];

  logic [AW-1:0] w_a0;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;
  logic [7:0]    w_b0;
  logic [7:0]    w_b1;
  logic [7:0]    w_b2;
  logic [7:0]    w_b3;
  logic [31:0]   w_word;
  logic [31:0]   w_ld;
  logic [2:0]    w_f3;
  logic          w_st_h;
  logic          w_st_w;
  logic [31:0]   w_wb;

  // Bundle the ID/EX and execute fields entering EX/MEM.
  always_comb begin
    w_ex_d          = '0;
    w_ex_d.memtoreg = memtoreg_IDEX_out;
    w_ex_d.regwrite = regwrite_IDEX_out;
    w_ex_d.memread  = memread_IDEX_out;
    w_ex_d.memwrite = memwrite_IDEX_out;
    w_ex_d.aj       = AJ_control_IDEX_out;
    w_ex_d.alu      = ALU_result;
    w_ex_d.rd2      = RD2_output;
    w_ex_d.f3       = function3_out_IDEX_out[2:0];
    w_ex_d.rd       = WData_IDEX_out;
    w_ex_d.pc4      = adder1_IDEX;
    w_ex_d.pcimm    = adder2_EXMEM;
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_ex_d;
    end
  end

  // Byte lanes wrap around the top of memory.
  assign w_a0   = r_ex.alu[AW-1:0];
  assign w_a1   = w_a0 + AW'(1);
  assign w_a2   = w_a0 + AW'(2);
  assign w_a3   = w_a0 + AW'(3);
  assign w_b0   = r_mem[w_a0];
  assign w_b1   = r_mem[w_a1];
  assign w_b2   = r_mem[w_a2];
  assign w_b3   = r_mem[w_a3];
  assign w_word = {w_b3, w_b2, w_b1, w_b0};
  assign w_f3   = r_ex.f3;
  assign w_st_h = (r_ex.f3[1:0] == 2'b01);
  assign w_st_w = r_ex.f3[1];

  // Store: bytewise write at the edge closing the MEM cycle.
  always_ff @(posedge clk) begin
    if (r_ex.memwrite) begin
      r_mem[w_a0] <= r_ex.rd2[7:0];
      if (w_st_h || w_st_w) begin
        r_mem[w_a1] <= r_ex.rd2[15:8];
      end
      if (w_st_w) begin
        r_mem[w_a2] <= r_ex.rd2[23:16];
        r_mem[w_a3] <= r_ex.rd2[31:24];
      end
    end
  end

  // Load formatting; reserved funct3 codes fall back to a word load.
  always_comb begin
    w_ld = '0;
    if (r_ex.memread) begin
      unique case (1'b1)
        (w_f3 == 3'b000): w_ld = {{24{w_b0[7]}}, w_b0};
        (w_f3 == 3'b001): w_ld = {{16{w_b1[7]}}, w_b1, w_b0};
        (w_f3 == 3'b100): w_ld = {24'h0, w_b0};
        (w_f3 == 3'b101): w_ld = {16'h0, w_b1, w_b0};
        default:          w_ld = w_word;
      endcase
    end
  end

  // Fields carried forward into MEM/WB.
  always_comb begin
    w_wb_d          = '0;
    w_wb_d.memtoreg = r_ex.memtoreg;
    w_wb_d.regwrite = r_ex.regwrite;
    w_wb_d.aj       = r_ex.aj;
    w_wb_d.alu      = r_ex.alu;
    w_wb_d.ldata    = w_ld;
    w_wb_d.rd       = r_ex.rd;
    w_wb_d.pc4      = r_ex.pc4;
    w_wb_d.pcimm    = r_ex.pcimm;
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb <= '0;
    end else begin
      r_wb <= w_wb_d;
    end
  end

  // Writeback source select.
  always_comb begin
    w_wb = '0;
    unique case (1'b1)
      (r_wb.aj == 2'b00): w_wb = r_wb.memtoreg ? r_wb.ldata : r_wb.alu;
      (r_wb.aj == 2'b01): w_wb = r_wb.pc4;
      (r_wb.aj == 2'b10): w_wb = r_wb.pcimm;
      default:            w_wb = r_wb.alu;
    endcase
  end

  assign regwrite_MEM_outt = w_wb;

`ifdef DEBUG_PORTS_EN
  assign wb_rd_o       = r_wb.rd;
  assign wb_regwrite_o = r_wb.regwrite;

  logic w_unused;
  assign w_unused = function3_out_IDEX_out[3];
`else
  logic w_unused;
  assign w_unused = ^{function3_out_IDEX_out[3], r_wb.regwrite, r_wb.rd};
`endif

endmodule

// File: tb/tb_menwb_tb.sv
// Bench for menwb_tb: directed MEM/WB scenarios plus random traffic
// checked against a transaction-level memory model.
module tb_menwb_tb;

  localparam int N = 4096;

  typedef struct {
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [1:0]  aj;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [3:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a1;
    logic [31:0] a2;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memtoreg;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic [1:0]  aj;
  logic [31:0] alu;
  logic [31:0] rd2;
  logic [3:0]  f3;
  logic [4:0]  rd;
  logic [31:0] a1;
  logic [31:0] a2;
  logic [31:0] wb;
`ifdef DEBUG_PORTS_EN
  logic [4:0]  dbg_rd;
  logic        dbg_rw;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  mm [N];
  logic [31:0] q_v [$];
  logic [4:0]  q_rd [$];
  logic        q_rw [$];
  string       q_tag [$];

  menwb_tb #(.DMEM_BYTES(N)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .memtoreg_IDEX_out      (memtoreg),
    .regwrite_IDEX_out      (regwrite),
    .memread_IDEX_out       (memread),
    .memwrite_IDEX_out      (memwrite),
    .AJ_control_IDEX_out    (aj),
    .ALU_result             (alu),
    .RD2_output             (rd2),
    .function3_out_IDEX_out (f3),
    .WData_IDEX_out         (rd),
    .adder1_IDEX            (a1),
    .adder2_EXMEM           (a2),
`ifdef DEBUG_PORTS_EN
    .wb_rd_o                (dbg_rd),
    .wb_regwrite_o          (dbg_rw),
`endif
    .regwrite_MEM_outt      (wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Whole transaction at once: read old bytes, then apply the store.
  function automatic logic [31:0] model(input txn_t t);
    int a;
    int nb;
    logic [31:0] w;
    logic [31:0] ld;
    a = int'(t.alu & 32'(N - 1));
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      w = w | (32'(mm[(a + i) % N]) << (8 * i));
    ld = 32'h0;
    if (t.memread) begin
      case (t.f3[2:0])
        3'b000:  ld = 32'($signed(w[7:0]));
        3'b001:  ld = 32'($signed(w[15:0]));
        3'b100:  ld = {24'h0, w[7:0]};
        3'b101:  ld = {16'h0, w[15:0]};
        default: ld = w;
      endcase
    end
    if (t.memwrite) begin
      nb = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++)
        mm[(a + i) % N] = 8'(t.rd2 >> (8 * i));
    end
    case (t.aj)
      2'b00:   return t.memtoreg ? ld : t.alu;
      2'b01:   return t.a1;
      2'b10:   return t.a2;
      default: return t.alu;
    endcase
  endfunction

  function automatic txn_t mk(input logic rd_en, input logic wr_en,
                              input logic m2r, input logic [1:0] sel,
                              input logic [3:0] fn, input logic [31:0] ad,
                              input logic [31:0] d);
    txn_t t;
    t.memread  = rd_en;
    t.memwrite = wr_en;
    t.memtoreg = m2r;
    t.aj       = sel;
    t.f3       = fn;
    t.alu      = ad;
    t.rd2      = d;
    t.regwrite = 1'($urandom);
    t.rd       = 5'($urandom);
    t.a1       = $urandom;
    t.a2       = $urandom;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    memtoreg = t.memtoreg;
    regwrite = t.regwrite;
    memread  = t.memread;
    memwrite = t.memwrite;
    aj       = t.aj;
    alu      = t.alu;
    rd2      = t.rd2;
    f3       = t.f3;
    rd       = t.rd;
    a1       = t.a1;
    a2       = t.a2;
  endtask

  // One cycle: launch t, then check the transaction launched one cycle earlier.
  task automatic step(input txn_t t, input string tag,
                      input logic use_want, input logic [31:0] want);
    logic [31:0] m;
    drive(t);
    m = model(t);
    q_v.push_back(use_want ? want : m);
    q_rd.push_back(t.rd);
    q_rw.push_back(t.regwrite);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    if (q_v.size() > 1) begin
      chk(q_tag.pop_front(), wb, q_v.pop_front());
`ifdef DEBUG_PORTS_EN
      chk("dbg_rd", 32'(dbg_rd), 32'(q_rd.pop_front()));
      chk("dbg_rw", 32'(dbg_rw), 32'(q_rw.pop_front()));
`else
      void'(q_rd.pop_front());
      void'(q_rw.pop_front());
`endif
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, wb, 32'h0);
`ifdef DEBUG_PORTS_EN
    chk({tag, "_rd"}, 32'(dbg_rd), 32'h0);
    chk({tag, "_rw"}, 32'(dbg_rw), 32'h0);
`endif
  endtask

  initial begin
    txn_t t;
    logic [31:0] r;
    for (int i = 0; i < N; i++) mm[i] = 8'h0;

    // Reset held with random inputs and a running clock.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(mk(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
               4'($urandom), $urandom, $urandom));
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    drive(mk(0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0));
    rst = 1'b1;

    // SW then LW.
    step(mk(0, 1, 0, 2'b00, 4'h2, 32'h10, 32'hDEADBEEF), "sw", 0, 0);
    step(mk(1, 0, 1, 2'b00, 4'h2, 32'h10, 32'h0), "lw", 1, 32'hDEADBEEF);
    // Byte and half loads.
    step(mk(0, 1, 0, 2'b00, 4'h0, 32'h21, 32'h80), "sb", 0, 0);
    step(mk(1, 0, 1, 2'b00, 4'h0, 32'h21, 32'h0), "lb", 1, 32'hFFFFFF80);
    step(mk(1, 0, 1, 2'b00, 4'h4, 32'h21, 32'h0), "lbu", 1, 32'h00000080);
    step(mk(0, 1, 0, 2'b00, 4'h1, 32'h30, 32'h8001), "sh", 0, 0);
    step(mk(1, 0, 1, 2'b00, 4'h1, 32'h30, 32'h0), "lh", 1, 32'hFFFF8001);
    step(mk(1, 0, 1, 2'b00, 4'h5, 32'h30, 32'h0), "lhu", 1, 32'h00008001);
    // Jump overrides.
    t = mk(1, 0, 1, 2'b01, 4'h2, 32'hA5A5A5A5, 32'h0);
    t.a1 = 32'h10;
    t.a2 = 32'h20;
    step(t, "jal_pc4", 1, 32'h00000010);
    t = mk(0, 1, 0, 2'b10, 4'h8, 32'hFFFF0000, 32'h123456FF);
    t.a2 = 32'h40;
    step(t, "auipc", 1, 32'h00000040);
    step(mk(1, 0, 1, 2'b00, 4'h2, 32'h0, 32'h0), "sb_hi_lw", 1, 32'h000000FF);
    // ALU path and LUI.
    step(mk(0, 0, 0, 2'b00, 4'h0, 32'h12345678, 32'h0), "alu", 1, 32'h12345678);
    step(mk(0, 0, 1, 2'b11, 4'h2, 32'h12345678, 32'h0), "lui", 1, 32'h12345678);
    // Wrap around the top of memory.
    step(mk(0, 1, 0, 2'b00, 4'h2, 32'(N - 2), 32'h11223344), "sw_wrap", 0, 0);
    step(mk(1, 0, 1, 2'b00, 4'h2, 32'(N - 2), 32'h0), "lw_wrap", 1, 32'h11223344);
    step(mk(1, 0, 1, 2'b00, 4'h2, 32'h0, 32'h0), "lw_wrap0", 1, 32'h00001122);
    // Load and store together, then misaligned and reserved formats.
    step(mk(1, 1, 1, 2'b00, 4'h2, 32'h10, 32'h01020304), "rdwr", 1, 32'hDEADBEEF);
    step(mk(1, 0, 1, 2'b00, 4'h2, 32'h10, 32'h0), "rdwr_new", 1, 32'h01020304);
    step(mk(1, 0, 1, 2'b00, 4'h2, 32'h11, 32'h0), "misalign", 1, 32'h00010203);
    step(mk(1, 0, 1, 2'b00, 4'h3, 32'h10, 32'h0), "f3_011", 1, 32'h01020304);
    step(mk(1, 0, 1, 2'b00, 4'h6, 32'h10, 32'h0), "f3_110", 1, 32'h01020304);
    step(mk(1, 0, 1, 2'b00, 4'h7, 32'h10, 32'h0), "f3_111", 1, 32'h01020304);
    step(mk(0, 0, 1, 2'b00, 4'h2, 32'h10, 32'h0), "noread", 1, 32'h0);

    // Reset dropped mid-stream, between edges.
    step(mk(0, 0, 0, 2'b11, 4'h0, 32'hCAFE0001, 32'h0), "pre_rst", 0, 0);
    step(mk(0, 0, 0, 2'b11, 4'h0, 32'hCAFE0002, 32'h0), "pre_rst", 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    chk_zero("rst_mid_edge");
    q_v.delete();
    q_rd.delete();
    q_rw.delete();
    q_tag.delete();
    drive(mk(0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0));
    rst = 1'b1;

    // Seed a window, then random traffic inside it.
    for (int i = 0; i < 16; i++)
      step(mk(0, 1, 0, 2'b00, 4'h2, 32'(32'h100 + 4 * i), $urandom), "fill", 0, 0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      t = mk(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
             4'($urandom),
             {r[31:12], 12'(32'h100 + $urandom_range(0, 60))},
             $urandom);
      step(t, "rand", 0, 0);
    end
    step(mk(0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0), "flush", 0, 0);
    step(mk(0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0), "flush", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
